// File: rtl/gmm_background_select.sv
// GMM background selection stage: fills B (background cluster count) and p_max_idx
// into a sorted beat through a 3-deep pipeline that stalls as one unit.

package gmm_background_select_pkg;
    localparam int MEM_W_WIDTH = 8;

    typedef struct packed {
        logic [1:0] clusters_num;
        logic [7:0] pixel;
    } in_t;

    typedef struct packed {
        in_t                              in;
        logic [2:0][7:0]                  mem_var;
        logic [2:0][MEM_W_WIDTH-1:0]      mem_w;
        logic [2:0][7:0]                  mem_color;
        logic [2:0][7:0]                  vars;
        logic [7:0]                       var_min;
        logic [7:0]                       var_max;
        logic [1:0]                       var_min_idx;
        logic [1:0]                       var_max_idx;
        logic [2:0]                       is_matched;
        logic [1:0]                       B;
        logic [1:0]                       p_max_idx;
    } mega_data_t;
endpackage

module gmm_background_select
    import gmm_background_select_pkg::*;
#(
    parameter int THRESH    = 179,
    parameter int W_WIDTH   = MEM_W_WIDTH,
    parameter int SUM_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           snk_valid,
    input  logic [$bits(mega_data_t)-1:0]  snk_data,
    output logic                           snk_ready,
    input  logic                           src_ready,
    output logic                           src_valid,
    output logic [$bits(mega_data_t)-1:0]  src_data
);

    localparam logic [SUM_WIDTH-1:0] THR = SUM_WIDTH'(THRESH);

    mega_data_t in_beat;
    logic [1:0] in_n;
    logic [W_WIDTH-1:0] we0, we1, we2;
    logic [SUM_WIDTH-1:0] c0_next, c1_next, c2_next;
    logic stall;

    logic                 s1_valid;
    mega_data_t           s1_data;
    logic [SUM_WIDTH-1:0] s1_c0, s1_c1, s1_c2;
    logic                 s1_m01;
    logic [W_WIDTH-1:0]   s1_we0, s1_we1, s1_we2;

    logic                 s2_valid;
    mega_data_t           s2_data;
    logic [2:0]           s2_f;
    logic [W_WIDTH-1:0]   s2_wm01, s2_we2;
    logic                 s2_m01;

    logic [1:0]           s1_n, s2_n;
    logic [2:0]           f_next;
    logic [1:0]           b_next, pmax_next;
    mega_data_t           s3_next;

    assign in_beat   = mega_data_t'(snk_data);
    assign in_n      = in_beat.in.clusters_num;
    assign stall     = src_valid & ~src_ready;
    assign snk_ready = ~stall;

    // Clusters beyond clusters_num contribute zero weight everywhere downstream.
    always_comb begin
        we0 = (in_n > 2'd0) ? in_beat.mem_w[0] : '0;
        we1 = (in_n > 2'd1) ? in_beat.mem_w[1] : '0;
        we2 = (in_n > 2'd2) ? in_beat.mem_w[2] : '0;
        c0_next = SUM_WIDTH'(we0);
        c1_next = SUM_WIDTH'(we0) + SUM_WIDTH'(we1);
        c2_next = SUM_WIDTH'(we0) + SUM_WIDTH'(we1) + SUM_WIDTH'(we2);
    end

    assign s1_n = s1_data.in.clusters_num;
    assign s2_n = s2_data.in.clusters_num;

    always_comb begin
        f_next[0] = (s1_c0 > THR) && (s1_n > 2'd0);
        f_next[1] = (s1_c1 > THR) && (s1_n > 2'd1);
        f_next[2] = (s1_c2 > THR) && (s1_n > 2'd2);
    end

    // First crossing wins; with no crossing every valid cluster counts as background.
    always_comb begin
        if (s2_f[0])
            b_next = 2'd1;
        else if (s2_f[1])
            b_next = 2'd2;
        else if (s2_f[2])
            b_next = 2'd3;
        else
            b_next = s2_n;
        pmax_next = ((s2_we2 > s2_wm01) && (s2_n == 2'd3)) ? 2'd2 : {1'b0, s2_m01};
        s3_next           = s2_data;
        s3_next.B         = b_next;
        s3_next.p_max_idx = pmax_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_c0     <= '0;
            s1_c1     <= '0;
            s1_c2     <= '0;
            s1_m01    <= 1'b0;
            s1_we0    <= '0;
            s1_we1    <= '0;
            s1_we2    <= '0;
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_f      <= '0;
            s2_wm01   <= '0;
            s2_we2    <= '0;
            s2_m01    <= 1'b0;
            src_valid <= 1'b0;
            src_data  <= '0;
        end else if (!stall) begin
            s1_valid  <= snk_valid;
            s1_data   <= in_beat;
            s1_c0     <= c0_next;
            s1_c1     <= c1_next;
            s1_c2     <= c2_next;
            s1_m01    <= (we1 > we0);
            s1_we0    <= we0;
            s1_we1    <= we1;
            s1_we2    <= we2;

            s2_valid  <= s1_valid;
            s2_data   <= s1_data;
            s2_f      <= f_next;
            s2_wm01   <= (s1_we1 > s1_we0) ? s1_we1 : s1_we0;
            s2_we2    <= s1_we2;
            s2_m01    <= s1_m01;

            src_valid <= s2_valid;
            src_data  <= s3_next;
        end
    end

endmodule

// File: tb/tb_gmm_background_select.sv
// Bench for gmm_background_select: directed threshold/argmax cases, backpressure,
// reset behaviour and a long random run against a cumulative-sum reference model.

module tb_gmm_background_select;
    import gmm_background_select_pkg::*;

    localparam int THRESH = 179;
    localparam int W      = $bits(mega_data_t);

    logic         clk = 1'b0;
    logic         rst;
    logic         snk_valid;
    logic [W-1:0] snk_data;
    logic         snk_ready;
    logic         src_ready;
    logic         src_valid;
    logic [W-1:0] src_data;

    always #5 clk = ~clk;

    gmm_background_select #(.THRESH(THRESH), .W_WIDTH(8), .SUM_WIDTH(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .snk_valid (snk_valid),
        .snk_data  (snk_data),
        .snk_ready (snk_ready),
        .src_ready (src_ready),
        .src_valid (src_valid),
        .src_data  (src_data)
    );

    int           n_asserts = 0;
    int           n_fail    = 0;
    mega_data_t   exp_q[$];
    logic         stalled_prev = 1'b0;
    logic [W-1:0] held = '0;
    logic         emitted = 1'b0;
    logic         accepted = 1'b0;
    mega_data_t   last_out;

    // Background count: walk clusters summing weights until the total exceeds THRESH.
    function automatic mega_data_t model(mega_data_t d);
        mega_data_t r = d;
        int n = int'(d.in.clusters_num);
        int sum = 0;
        int b = n;
        int found = 0;
        int best = 0;
        int bw = -1;
        for (int k = 0; k < n; k++) begin
            sum += int'(d.mem_w[k]);
            if (found == 0 && sum > THRESH) begin
                b = k + 1;
                found = 1;
            end
            if (int'(d.mem_w[k]) > bw) begin
                bw = int'(d.mem_w[k]);
                best = k;
            end
        end
        r.B = 2'(b);
        r.p_max_idx = 2'(best);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: apply inputs, sample outputs, then advance one clock.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic rdy);
        mega_data_t e;
        snk_valid = v;
        snk_data  = d;
        src_ready = rdy;
        #1;
        check("snk_ready", W'(snk_ready), W'(!(src_valid && !rdy)));
        if (stalled_prev)
            check("stall_hold", src_data, held);
        emitted  = 1'b0;
        accepted = 1'b0;
        if (src_valid && rdy) begin
            n_asserts++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_beat: observed %h expected none", src_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("beat", src_data, e);
            end
            last_out = mega_data_t'(src_data);
            emitted  = 1'b1;
        end
        if (v && snk_ready) begin
            exp_q.push_back(model(mega_data_t'(d)));
            accepted = 1'b1;
        end
        stalled_prev = src_valid && !rdy;
        held         = src_data;
        @(negedge clk);
    endtask

    typedef struct {
        int n; int w0; int w1; int w2; int b; int p;
    } dcase_t;

    initial begin
        dcase_t cases[$];
        mega_data_t bt;
        int lat;
        int cnt;
        int guard;
        int pat;

        rst = 1'b0;
        snk_valid = 1'b1;
        snk_data = rand_beat();
        src_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_valid", W'(src_valid), W'(0));
        check("reset_data", src_data, '0);
        rst = 1'b1;

        // Latency: accepted beat appears on the third sample after acceptance
        lat = -1;
        cycle(1'b1, rand_beat(), 1'b1);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, '0, 1'b1);
            if (emitted && lat < 0)
                lat = i;
        end
        check("latency", W'(lat), W'(3));

        cases.push_back('{3, 200, 50, 5, 1, 0});
        cases.push_back('{3, 100, 90, 60, 2, 0});
        cases.push_back('{3, 60, 60, 50, 3, 0});
        cases.push_back('{2, 100, 50, 255, 2, 0});
        cases.push_back('{0, 255, 255, 255, 0, 0});
        cases.push_back('{1, 10, 0, 0, 1, 0});
        cases.push_back('{3, 80, 80, 80, 3, 0});
        cases.push_back('{3, 10, 20, 30, 3, 2});
        cases.push_back('{3, 5, 7, 3, 3, 1});
        foreach (cases[i]) begin
            bt = mega_data_t'(rand_beat());
            bt.in.clusters_num = 2'(cases[i].n);
            bt.mem_w[0] = 8'(cases[i].w0);
            bt.mem_w[1] = 8'(cases[i].w1);
            bt.mem_w[2] = 8'(cases[i].w2);
            cycle(1'b1, W'(bt), 1'b1);
            cnt = 0;
            for (int j = 0; j < 6 && cnt == 0; j++) begin
                cycle(1'b0, '0, 1'b1);
                if (emitted) cnt = 1;
            end
            check($sformatf("dir%0d_emit", i), W'(cnt), W'(1));
            check($sformatf("dir%0d_B", i), W'(last_out.B), W'(cases[i].b));
            check($sformatf("dir%0d_pmax", i), W'(last_out.p_max_idx), W'(cases[i].p));
        end

        // Backpressure: src_ready pattern 1,0,0,1
        cnt = 0;
        pat = 0;
        guard = 0;
        while (cnt < 8 && guard < 60) begin
            cycle(1'b1, rand_beat(), (pat % 4 == 0) || (pat % 4 == 3));
            if (accepted) cnt++;
            pat++;
            guard++;
        end
        check("bp_accepted", W'(cnt), W'(8));
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            cycle(1'b0, '0, (pat % 4 == 0) || (pat % 4 == 3));
            pat++;
            guard++;
        end
        check("bp_drained", W'(exp_q.size()), W'(0));

        // Reset while stalled drops every held beat
        for (int i = 0; i < 5; i++)
            cycle(1'b1, rand_beat(), 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        stalled_prev = 1'b0;
        check("midstall_reset_valid", W'(src_valid), W'(0));
        for (int i = 0; i < 5; i++)
            cycle(1'b0, '0, 1'b1);

        // Long random run
        cnt = 0;
        guard = 0;
        while (cnt < 10000 && guard < 40000) begin
            cycle($urandom_range(0, 3) != 0, rand_beat(), $urandom_range(0, 3) != 0);
            if (accepted) cnt++;
            guard++;
        end
        check("rand_accepted", W'(cnt), W'(10000));
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            cycle(1'b0, '0, 1'b1);
            guard++;
        end
        check("rand_drained", W'(exp_q.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
